// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the counter enable sequencer: state encoding and default widths.
package count_ctrl_pkg;

  localparam int unsigned DIV_W_DEF   = 16;
  localparam int unsigned BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2,
    STEP  = 2'd3
  } state_e;

  // Prescaler only advances while a run or burst is active.
  function automatic logic is_counting(input state_e s);
    return (s == RUN) || (s == BURST);
  endfunction

endpackage

// File: rtl/count_ctrl_tick_prescaler.sv
// Free-running divide-by-(div+1) counter; terminal-count strobe marks the enable edges.
module tick_prescaler
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tc_c_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tc_c_o = run_i && !clear_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tc_c_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Enable sequencer for the downstream 8-bit counter: prescaled run, N-pulse burst and single step.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [BURST_W-1:0] remaining
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  // Set on the edge issuing the final burst/step enable; becomes done one cycle later.
  logic               last_q, last_d;
  logic               counting_c;
  logic               tick_c;

  assign counting_c = is_counting(state_q);

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (!counting_c),
    .run_i   (counting_c),
    .div_i   (div_q),
    .tc_c_o  (tick_c)
  );

  // Next-state and output decode; stop outranks start, start outranks step.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    en_d    = 1'b0;
    done_d  = last_q;
    abort_d = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop) begin
          if (start) begin
            div_d = cfg_div;
            if (cfg_burst == '0) begin
              state_d = RUN;
            end else begin
              state_d = BURST;
              rem_d   = cfg_burst;
            end
          end else if (step) begin
            state_d = STEP;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          en_d = tick_c;
        end
      end
      BURST: begin
        if (stop) begin
          state_d = IDLE;
          abort_d = 1'b1;
          rem_d   = '0;
        end else if (tick_c) begin
          en_d  = 1'b1;
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
        end
      end
      STEP: begin
        state_d = IDLE;
        if (stop) begin
          abort_d = 1'b1;
        end else begin
          en_d   = 1'b1;
          last_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      rem_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      last_q  <= last_d;
    end
  end

  assign enable    = en_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign aborted   = abort_q;
  assign remaining = rem_q;

endmodule
